// File: rtl/vga_timing_gen_if.sv
// Raster-timing bundle between the VGA timing generator and its consumer.
// Colour-bar signals exist only when TEST_PATTERN_EN is defined.
interface vga_timing_gen_if #(
  parameter int X_W = 10,
  parameter int Y_W = 10
);
  logic           en;
  logic           hsync;
  logic           vsync;
  logic           de;
  logic [X_W-1:0] px_x;
  logic [Y_W-1:0] px_y;
  logic           line_start;
  logic           frame_start;
`ifdef TEST_PATTERN_EN
  logic           red;
  logic           green;
  logic           blue;
  logic           intense;

  modport master (input en, output hsync, vsync, de, px_x, px_y, line_start, frame_start,
                  red, green, blue, intense);
  modport slave  (output en, input hsync, vsync, de, px_x, px_y, line_start, frame_start,
                  red, green, blue, intense);
`else
  modport master (input en, output hsync, vsync, de, px_x, px_y, line_start, frame_start);
  modport slave  (output en, input hsync, vsync, de, px_x, px_y, line_start, frame_start);
`endif
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: h/v counters plus registered sync/de/coordinate decode.
// Define TEST_PATTERN_EN to add a registered 16-colour bar pattern on the RGBI outputs.
module vga_timing_gen #(
  parameter int   H_ACTIVE  = 640,
  parameter int   H_FP      = 16,
  parameter int   H_SYNC    = 96,
  parameter int   H_BP      = 48,
  parameter int   V_ACTIVE  = 480,
  parameter int   V_FP      = 10,
  parameter int   V_SYNC    = 2,
  parameter int   V_BP      = 33,
  parameter logic HSYNC_POL = 1'b0,
  parameter logic VSYNC_POL = 1'b0,
  parameter int   X_W       = 10,
  parameter int   Y_W       = 10
) (
  input logic             clk,
  input logic             nrst,
  vga_timing_gen_if.master bus
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [X_W-1:0] H_LAST = X_W'(H_TOTAL - 1);
  localparam logic [X_W-1:0] H_VIS  = X_W'(H_ACTIVE);
  localparam logic [X_W-1:0] HS_BEG = X_W'(H_ACTIVE + H_FP);
  localparam logic [X_W-1:0] HS_END = X_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [Y_W-1:0] V_LAST = Y_W'(V_TOTAL - 1);
  localparam logic [Y_W-1:0] V_VIS  = Y_W'(V_ACTIVE);
  localparam logic [Y_W-1:0] VS_BEG = Y_W'(V_ACTIVE + V_FP);
  localparam logic [Y_W-1:0] VS_END = Y_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [X_W-1:0] r_h, r_px_x;
  logic [Y_W-1:0] r_v, r_px_y;
  logic           r_hsync, r_vsync, r_de, r_line_start, r_frame_start;
  logic           w_h_last, w_v_last, w_de, w_hs_on, w_vs_on;

  assign w_h_last = (r_h == H_LAST);
  assign w_v_last = (r_v == V_LAST);
  assign w_de     = (r_h < H_VIS) && (r_v < V_VIS);
  assign w_hs_on  = (r_h >= HS_BEG) && (r_h < HS_END);
  assign w_vs_on  = (r_v >= VS_BEG) && (r_v < VS_END);

  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_h <= '0;
      r_v <= '0;
    end else if (bus.en) begin
      if (w_h_last) begin
        r_h <= '0;
        r_v <= w_v_last ? '0 : r_v + 1'b1;
      end else begin
        r_h <= r_h + 1'b1;
      end
    end
  end

  // Outputs decode the pre-increment count, so they trail the counters by one en-cycle.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_hsync       <= ~HSYNC_POL;
      r_vsync       <= ~VSYNC_POL;
      r_de          <= 1'b0;
      r_px_x        <= '0;
      r_px_y        <= '0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else if (bus.en) begin
      r_hsync       <= w_hs_on ? HSYNC_POL : ~HSYNC_POL;
      r_vsync       <= w_vs_on ? VSYNC_POL : ~VSYNC_POL;
      r_de          <= w_de;
      r_px_x        <= r_h;
      r_px_y        <= r_v;
      r_line_start  <= (r_h == '0);
      r_frame_start <= (r_h == '0) && (r_v == '0);
    end else begin
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end
  end

  assign bus.hsync       = r_hsync;
  assign bus.vsync       = r_vsync;
  assign bus.de          = r_de;
  assign bus.px_x        = r_px_x;
  assign bus.px_y        = r_px_y;
  assign bus.line_start  = r_line_start;
  assign bus.frame_start = r_frame_start;

`ifdef TEST_PATTERN_EN
  // 64-pixel bars: h[9:6] maps straight onto {intense,red,green,blue}.
  logic [3:0] r_rgbi;

  always_ff @(posedge clk) begin
    if (!nrst)        r_rgbi <= 4'd0;
    else if (bus.en)  r_rgbi <= w_de ? r_h[9:6] : 4'd0;
  end

  assign {bus.intense, bus.red, bus.green, bus.blue} = r_rgbi;
`endif
endmodule
